// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB memory completer.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Transfer states; IDLE also covers the APB setup phase.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Largest supported number of inserted wait states and the counter width.
  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned WAIT_CNT_W      = 4;

endpackage
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : apb_mem_array
// Description : DEPTH x DATA_WIDTH storage, one write port and one registered
//               read port whose output reads as zero unless a read launched.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port; storage is deliberately not reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; the output falls back to zero on every edge without a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_mem_slave
// Description : APB3 completer with word-addressed memory, programmable wait
//               states, read-only upper region and PSLVERR error responses.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = DEPTH
) (
  input  logic                  PCLK,
  input  logic                  RESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   c_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_RO_BASE = (ADDR_WIDTH+1)'(RO_BASE);
  localparam logic [WAIT_CNT_W-1:0] c_WAIT    = WAIT_CNT_W'(WAIT_STATES);

  apb_state_t              r_state, w_nxt_state;
  logic [WAIT_CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_nxt_addr;
  logic                    r_wr, w_nxt_wr;
  logic                    r_err, w_nxt_err;
  logic                    w_range_err, w_ro_err;
  logic                    w_access, w_we, w_re;

  assign w_range_err = ({1'b0, PADDR} >= c_DEPTH);
  assign w_ro_err    = ({1'b0, PADDR} >= c_RO_BASE);

  // Next-state, wait counter and setup-phase capture of address/direction/error.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_addr  = r_addr;
    w_nxt_wr    = r_wr;
    w_nxt_err   = r_err;
    case (r_state)
      IDLE: begin
        if (PSEL) begin
          w_nxt_addr = PADDR;
          w_nxt_wr   = PWRITE;
          if (PENABLE) begin
            // Access phase without a setup phase: answer with a single error cycle.
            w_nxt_err   = 1'b1;
            w_nxt_state = ACCESS;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_err = w_range_err || (PWRITE && w_ro_err);
            if (c_WAIT != '0) begin
              w_nxt_state = WAIT;
              w_nxt_cnt   = c_WAIT;
            end else begin
              w_nxt_state = ACCESS;
              w_nxt_cnt   = '0;
            end
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
          if (r_cnt == 1) begin
            w_nxt_state = ACCESS;
          end
        end
      end
      ACCESS: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // State and captured-transfer registers.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_addr  <= w_nxt_addr;
      r_wr    <= w_nxt_wr;
      r_err   <= w_nxt_err;
    end
  end

  // Responses come purely from registered state.
  assign w_access = (r_state == ACCESS);
  assign PREADY   = w_access;
  assign PSLVERR  = w_access && r_err;

  // Commit at the edge ending ACCESS unless the requester has dropped PSEL.
  assign w_we = w_access && PSEL && r_wr && !r_err;

  // Launch the read on the edge entering ACCESS; with zero wait states that
  // edge is also the setup edge, hence the use of the next-cycle address.
  assign w_re = (w_nxt_state == ACCESS) && !w_access && !w_nxt_wr && !w_nxt_err;

  apb_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (PCLK),
    .rst    (RESET),
    .i_we   (w_we),
    .i_waddr(r_addr),
    .i_wdata(PWDATA),
    .i_re   (w_re),
    .i_raddr(w_nxt_addr),
    .o_rdata(PRDATA)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_mem_slave
// Description : Directed bench for apb_mem_slave; DUT 0 has two wait states,
//               DUT 1 has none. A transfer-level model predicts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel   [2];
  logic        pen    [2];
  logic        pwr    [2];
  logic [7:0]  paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr[2];

  // Expected outputs for the current cycle, per DUT.
  logic        exp_rdy[2];
  logic        exp_err[2];
  logic [31:0] exp_rd [2];
  logic        exp_vld[2];

  // Memory model: contents plus a flag saying whether the word is known.
  logic [31:0] mdl_mem[2][256];
  logic        mdl_kn [2][256];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          last_rdy;
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200),
                  .WAIT_STATES(2), .RO_BASE(192)) u_dut0 (
    .PCLK(clk), .RESET(rst), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200),
                  .WAIT_STATES(0), .RO_BASE(192)) u_dut1 (
    .PCLK(clk), .RESET(rst), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
  endtask

  task automatic set_quiet(input int d);
    exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = '0; exp_vld[d] = 1'b1;
  endtask

  // Cycle-by-cycle comparison of both DUTs against the model's expectations.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("PREADY", d, {31'b0, pready[d]}, {31'b0, exp_rdy[d]});
      chk("PSLVERR", d, {31'b0, pslverr[d]}, {31'b0, exp_err[d]});
      if (exp_vld[d]) chk("PRDATA", d, prdata[d], exp_rd[d]);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        psel[d] = 1'b0; pen[d] = 1'b0; set_quiet(d);
      end
    end
  endtask

  // One APB transfer. abort_at >= 1 drops PSEL in that access-phase cycle.
  // After setup, PADDR/PWRITE are scrambled: the DUT must use latched values.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input int abort_at);
    int   ws;
    int   last_k;
    logic e;
    ws     = (d == 0) ? 2 : 0;
    e      = (a >= 8'd200) || (wr && (a >= 8'd192));
    last_k = (abort_at >= 0) ? abort_at + 1 : ws + 1;
    last_rdy = -1;
    for (int k = 0; k <= last_k; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd;
      end else begin
        pen[d] = 1'b1; paddr[d] = a ^ 8'h55; pwr[d] = ~wr;
      end
      if (abort_at >= 0 && k >= abort_at) begin
        psel[d] = 1'b0; pen[d] = 1'b0;
      end
      set_quiet(d);
      if (abort_at < 0 && k == ws + 1) begin
        exp_rdy[d] = 1'b1;
        exp_err[d] = e;
        if (!wr && !e) begin
          exp_rd[d]  = mdl_mem[d][a];
          exp_vld[d] = mdl_kn[d][a];
        end
      end
      @(negedge clk);
      if (pready[d] && last_rdy < 0) last_rdy = k;
      if (k == last_k) begin
        last_rdata = prdata[d];
        last_err   = pslverr[d];
      end
    end
    if (abort_at < 0 && wr && !e) begin
      mdl_mem[d][a] = wd;
      mdl_kn[d][a]  = 1'b1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      set_quiet(d);
      for (int i = 0; i < 256; i++) begin
        mdl_mem[d][i] = '0; mdl_kn[d][i] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Write then read, two wait states: PREADY in the 4th cycle.
    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, -1);
    chk("WR_RDY_CYCLE", 0, 32'(last_rdy), 32'd3);
    xfer(0, 1'b0, 8'h10, 32'h0, -1);
    chk("RD_RDY_CYCLE", 0, 32'(last_rdy), 32'd3);
    chk("RD_DATA", 0, last_rdata, 32'hDEADBEEF);
    chk("RD_ERR", 0, {31'b0, last_err}, 32'd0);

    // Out-of-range read.
    xfer(0, 1'b0, 8'hC8, 32'h0, -1);
    chk("OOR_ERR", 0, {31'b0, last_err}, 32'd1);
    chk("OOR_DATA", 0, last_rdata, 32'd0);

    // Write into the read-only region is refused and leaves the word alone.
    xfer(0, 1'b1, 8'hC0, 32'h12345678, -1);
    chk("RO_ERR", 0, {31'b0, last_err}, 32'd1);
    xfer(0, 1'b0, 8'hC0, 32'h0, -1);
    chk("RO_KEPT", 0, {31'b0, (last_rdata == 32'h12345678)}, 32'd0);
    chk("RO_RD_ERR", 0, {31'b0, last_err}, 32'd0);

    // Abort during WAIT leaves old data in place.
    xfer(0, 1'b1, 8'h20, 32'h01020304, -1);
    xfer(0, 1'b1, 8'h20, 32'hFFFFFFFF, 1);
    idle(1);
    xfer(0, 1'b0, 8'h20, 32'h0, -1);
    chk("ABORT_OLD", 0, last_rdata, 32'h01020304);

    // Protocol violation: PSEL and PENABLE together straight from IDLE.
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b1; paddr[0] = 8'h10; pwdata[0] = 32'hBAD0BAD0;
    set_quiet(0);
    @(posedge clk); #1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    exp_rdy[0] = 1'b1; exp_err[0] = 1'b1; exp_rd[0] = '0; exp_vld[0] = 1'b1;
    @(negedge clk);
    chk("PV_RDY", 0, {31'b0, pready[0]}, 32'd1);
    chk("PV_ERR", 0, {31'b0, pslverr[0]}, 32'd1);
    idle(1);
    xfer(0, 1'b0, 8'h10, 32'h0, -1);
    chk("PV_NOWRITE", 0, last_rdata, 32'hDEADBEEF);

    // Reset during WAIT of a write: pending write is dropped.
    xfer(0, 1'b1, 8'h30, 32'h11112222, -1);
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b1; paddr[0] = 8'h30; pwdata[0] = 32'hA5A5A5A5;
    set_quiet(0);
    @(posedge clk); #1;
    pen[0] = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("RSTW_RDY", 0, {31'b0, pready[0]}, 32'd0);
    chk("RSTW_ERR", 0, {31'b0, pslverr[0]}, 32'd0);
    chk("RSTW_DATA", 0, prdata[0], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel[0] = 1'b0; pen[0] = 1'b0;
    idle(1);
    xfer(0, 1'b0, 8'h30, 32'h0, -1);
    chk("RSTW_NOCOMMIT", 0, {31'b0, (last_rdata == 32'hA5A5A5A5)}, 32'd0);

    // Reset during ACCESS of a read clears the live outputs at once.
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b0; pwr[0] = 1'b0; paddr[0] = 8'h10;
    set_quiet(0);
    repeat (2) begin
      @(posedge clk); #1;
      pen[0] = 1'b1;
    end
    @(posedge clk); #1;
    exp_rdy[0] = 1'b1; exp_rd[0] = 32'hDEADBEEF;
    #1;
    chk("RSTA_PRE_RDY", 0, {31'b0, pready[0]}, 32'd1);
    chk("RSTA_PRE_DATA", 0, prdata[0], 32'hDEADBEEF);
    rst = 1'b1;
    set_quiet(0);
    #1;
    chk("RSTA_RDY", 0, {31'b0, pready[0]}, 32'd0);
    chk("RSTA_DATA", 0, prdata[0], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; psel[0] = 1'b0; pen[0] = 1'b0;
    idle(1);

    // Zero wait states: back-to-back writes then back-to-back reads.
    for (int i = 0; i < 4; i++) xfer(1, 1'b1, 8'(i), 32'hC0DE0000 + 32'(i), -1);
    chk("B2B_WR_RDY_CYCLE", 1, 32'(last_rdy), 32'd1);
    for (int i = 0; i < 4; i++) xfer(1, 1'b0, 8'(i), 32'h0, -1);
    chk("B2B_RD_RDY_CYCLE", 1, 32'(last_rdy), 32'd1);
    chk("B2B_LAST_DATA", 1, last_rdata, 32'hC0DE0003);

    // Read-after-write in consecutive zero-wait transfers.
    xfer(1, 1'b1, 8'h40, 32'h5A5A0F0F, -1);
    xfer(1, 1'b0, 8'h40, 32'h0, -1);
    chk("RAW_DATA", 1, last_rdata, 32'h5A5A0F0F);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB3 completer with a word-addressed internal memory, programmable wait states (PREADY), and error signalling (PSLVERR). It replaces the fixed 8-bit, zero-wait APB slave as the generic memory/register target on the team's APB fabric. It is the DUT for the UVM APB agent in both completer and error-injection modes.

## Interface
Parameters:
- ADDR_WIDTH, 8, PADDR width; word address, no byte lanes.
- DATA_WIDTH, 32, PWDATA/PRDATA width (8, 16 or 32).
- DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH.
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..15).
- RO_BASE, DEPTH, first read-only word; addresses RO_BASE..DEPTH-1 are read-only; default means none.

Ports:
- PCLK  input  1  clock; all logic on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  word address.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data.
- PREADY  output  1  transfer completes in the cycle it is high.
- PSLVERR  output  1  error response; valid only while PREADY is high.

## Operation
- FSM states: IDLE, WAIT, ACCESS. IDLE also covers the APB setup phase.
- IDLE, PSEL=1, PENABLE=0 at the edge:
  - Latch PADDR and PWRITE into addr_q and wr_q.
  - Compute err_q = (PADDR ≥ DEPTH) or (PWRITE and PADDR ≥ RO_BASE).
  - Next state is WAIT with wait count = WAIT_STATES if WAIT_STATES > 0, else ACCESS.
- WAIT: decrement the count each edge. When the count reaches 1, the next state is ACCESS.
- ACCESS: PREADY = 1 and PSLVERR = err_q. The next state is always IDLE.
- Write commit: mem[addr_q] ← PWDATA at the edge ending ACCESS, only if wr_q=1 and err_q=0.
- Read: on entry to ACCESS, PRDATA is loaded with mem[addr_q] if wr_q=0 and err_q=0, else 0.
- PRDATA returns to 0 at the edge leaving ACCESS.
- Protocol violation: IDLE with PSEL=1 and PENABLE=1 (no setup phase).
  - Next state is ACCESS with err_q=1.
  - Response is one PREADY/PSLVERR cycle, no write, PRDATA=0.
- Abort: PSEL=0 in WAIT or ACCESS.
  - Next state is IDLE, no write, and PSLVERR stays 0.
  - PREADY is 0 from the next cycle onward.
- PADDR or PWRITE changes after setup are ignored, because the latched values are used.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, PRDATA 0, PREADY 0, PSLVERR 0, wait count 0, addr_q/wr_q/err_q 0.
- Latency from the setup cycle to the PREADY cycle is 1 + WAIT_STATES cycles.
  - Total transfer is 2 + WAIT_STATES cycles.
  - PREADY is low for exactly WAIT_STATES access cycles.
- PREADY and PSLVERR are decoded from registered state only, with no combinational path from inputs.
- Back-to-back transfers: the cycle after ACCESS may be a new setup (IDLE sees it); there are no dead cycles.
- Read-after-write to the same address in consecutive transfers returns the new data.
- Reset asserted mid-transfer:
  - Immediately returns to IDLE and clears all outputs.
  - A pending write is not committed.

## Structure
- Shared package apb_pkg: state enum (IDLE, WAIT, ACCESS), 2-bit state type, and the WAIT_STATES bound constant (15).
- Sub-module apb_mem_array: DEPTH×DATA_WIDTH storage with one write port and one registered read port.
- The FSM, error decode and wait counter live in apb_mem_slave.

## Test plan
Configuration for all scenarios: DATA_WIDTH=32, DEPTH=200, RO_BASE=192, WAIT_STATES=2 unless noted.
- Write then read:
  - Stimulus: write 0xDEADBEEF to 0x10, then read 0x10.
  - Required: PREADY high in the 4th cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- Out-of-range read:
  - Stimulus: read 0xC8.
  - Required: PSLVERR=1 with PREADY, PRDATA=0.
- Read-only region:
  - Stimulus: write 0x12345678 to 0xC0.
  - Required: PSLVERR=1, and a subsequent read of 0xC0 returns its prior contents.
- Back-to-back zero-wait transfers:
  - Stimulus: WAIT_STATES=0, writes to 0x00..0x03 with no idle gaps, then reads.
  - Required: each transfer takes 2 cycles and the reads return the written data.
- Abort and protocol violation:
  - Stimulus: drop PSEL during WAIT of a write to 0x20, then read 0x20.
  - Required: the old data is read back.
  - Stimulus: PSEL=PENABLE=1 from IDLE.
  - Required: one cycle with PREADY=1 and PSLVERR=1.
- Reset mid-write:
  - Stimulus: assert RESET during WAIT of a write of 0xA5A5A5A5 to 0x30.
  - Required: all outputs 0 immediately, and a read of 0x30 does not return 0xA5A5A5A5.
